// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between NUM_REQ requesters and the register-file write port.
// The slave side is the arbiter; the master side is whoever drives the requests.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic            enable;
        logic [4:0]      which_register;
        logic [XLEN-1:0] value;
    } reg_write_control_t;

    logic [NUM_REQ-1:0] req_valid;
    logic [4:0]         req_reg   [NUM_REQ];
    logic [XLEN-1:0]    req_value [NUM_REQ];
    logic [NUM_REQ-1:0] req_ready;
    reg_write_control_t write_control;
    logic [IDX_W-1:0]   wc_src;
    logic               wc_valid;

    modport slave (
        input  req_valid, req_reg, req_value,
        output req_ready, write_control, wc_src, wc_valid
    );

    modport master (
        output req_valid, req_reg, req_value,
        input  req_ready, write_control, wc_src, wc_valid
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// NUM_REQ writeback requesters; the winning write is registered for one cycle.
module regfile_wb_arbiter #(
    parameter int  NUM_REQ = 2,
    parameter int  XLEN    = 32,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave wb_io
);

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   cand;
    logic               gnt_any;
    logic               take;
    logic [NUM_REQ-1:0] ready;

    logic               wc_enable_q, wc_enable_d;
    logic [4:0]         wc_reg_q,    wc_reg_d;
    logic [XLEN-1:0]    wc_value_q,  wc_value_d;
    logic [IDX_W-1:0]   wc_src_q,    wc_src_d;
    logic               wc_valid_q,  wc_valid_d;

    // Scan from the priority pointer and take the first valid requester.
    always_comb begin : rr_scan
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!gnt_any && wb_io.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // No handshake completes while reset is held, even before the first edge.
    assign take = gnt_any && !rst;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign ready[gi] = take && (gnt_idx == IDX_W'(gi));
    end

    assign wb_io.req_ready = ready;

    always_comb begin : next_state
        ptr_d       = ptr_q;
        wc_enable_d = 1'b0;
        wc_valid_d  = 1'b0;
        wc_reg_d    = wc_reg_q;
        wc_value_d  = wc_value_q;
        wc_src_d    = wc_src_q;
        if (take) begin
            ptr_d       = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            wc_reg_d    = wb_io.req_reg[gnt_idx];
            wc_value_d  = wb_io.req_value[gnt_idx];
            wc_src_d    = gnt_idx;
            wc_valid_d  = 1'b1;
            // Writes to x0 are consumed but never reach the register file.
            wc_enable_d = (wb_io.req_reg[gnt_idx] != 5'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            wc_enable_q <= 1'b0;
            wc_reg_q    <= '0;
            wc_value_q  <= '0;
            wc_src_q    <= '0;
            wc_valid_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            wc_enable_q <= wc_enable_d;
            wc_reg_q    <= wc_reg_d;
            wc_value_q  <= wc_value_d;
            wc_src_q    <= wc_src_d;
            wc_valid_q  <= wc_valid_d;
        end
    end

    assign wb_io.write_control = {wc_enable_q, wc_reg_q, wc_value_q};
    assign wb_io.wc_src        = wc_src_q;
    assign wb_io.wc_valid      = wc_valid_q;

endmodule
